falafel_mem_responder: RTL and testbench
========================================

FALAFEL_MEM_RESPONDER -- requirements
Module: falafel_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of DATA_W-bit words in the internal array; SHALL be a power of two >= 2.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response valid; SHALL be >= 1.
REQ-003 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 mem_req_val_i  in  1  request valid.
REQ-006 mem_req_rdy_o  out  1  responder ready to accept a request.
REQ-007 mem_req_is_write_i  in  1  1 = store, 0 = load.
REQ-008 mem_req_is_cas_i  in  1  1 = compare-and-swap; overrides is_write.
REQ-009 mem_req_addr_i  in  DATA_W  byte address.
REQ-010 mem_req_data_i  in  DATA_W  store data / CAS swap value.
REQ-011 mem_req_cas_exp_i  in  DATA_W  CAS expected value.
REQ-012 mem_rsp_val_o  out  1  response valid.
REQ-013 mem_rsp_rdy_i  in  1  requester ready for the response.
REQ-014 mem_rsp_data_o  out  DATA_W  response data.

Function
REQ-015 FSM states IDLE, BUSY, RESP; exactly one request outstanding at a time.
REQ-016 IDLE: mem_req_rdy_o=1 (subject to REQ-030); mem_rsp_val_o=0; mem_req_val_i=1 while rdy=1 is an accept.
REQ-017 Word index = (mem_req_addr_i / (DATA_W/8)) mod DEPTH; low byte-offset bits ignored; indices beyond DEPTH wrap.
REQ-018 On accept edge: load latches mem[idx]; store writes mem[idx]=data, latches 0; CAS: if mem[idx]==cas_exp write mem[idx]=data and latch 0, else leave mem unchanged and latch 1.
REQ-019 On accept, LATENCY=1 goes to RESP; LATENCY>1 goes to BUSY with counter loaded to LATENCY-1.
REQ-020 BUSY: rdy=0, rsp_val=0; counter decrements each cycle; on reaching 0 transitions to RESP, so rsp_val rises exactly LATENCY cycles after the accept edge.
REQ-021 RESP: rsp_val=1, rsp_data=latched value, both held stable until mem_rsp_rdy_i=1; rdy=0.
REQ-022 RESP with mem_rsp_rdy_i=1: response consumed, next state IDLE; no new request accepted in that same cycle.
REQ-023 Request inputs are ignored outside IDLE; a request held valid across RESP->IDLE is accepted in IDLE.
REQ-024 is_cas=1 with is_write=1 SHALL execute as CAS.
REQ-025 Stores and CAS always produce a response, including when data is unchanged.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE, counter 0, latched response 0, mem_rsp_val_o=0, mem_rsp_data_o=0, mem_req_rdy_o=0 while asserted.
REQ-027 Reset SHALL clear every array word to 0 (EMPTY_KEY-compatible start for lock words).
REQ-028 Reset mid-BUSY or mid-RESP SHALL discard the pending response; the array write from the accept edge persists unless cleared by REQ-027.
REQ-029 First accept possible on the first rising edge after rst_ni deasserts.

Configuration
REQ-030 Macro FALAFEL_MEM_STALL_EN: when defined, an 8-bit maximal-length LFSR (seed 8'hA5 on reset, advances every cycle) gates readiness: in IDLE mem_req_rdy_o = ~lfsr[0]; when undefined, mem_req_rdy_o=1 throughout IDLE and no LFSR exists.

Verification
REQ-031 Reset, store addr 0x10 data 0x1234 -> one response data 0 at LATENCY=2; then load addr 0x10 -> rsp_data 0x1234 exactly 2 cycles after accept.
REQ-032 After reset, CAS addr 0x20 exp 0 data 0x7 -> rsp 0; second identical CAS -> rsp 1; load addr 0x20 -> 0x7.
REQ-033 mem_rsp_rdy_i held low 5 cycles in RESP -> rsp_val and rsp_data stable, rdy=0, no second accept; rdy released -> IDLE next cycle.
REQ-034 DEPTH=16, DATA_W=32: store addr 0x44 data 0xAB, load addr 0x04 -> 0xAB (wrap); load addr 0x06 -> 0xAB (offset ignored).
REQ-035 Reset asserted during BUSY -> rsp_val never rises, state IDLE after release, load of that address returns 0.
REQ-036 FALAFEL_MEM_STALL_EN defined, val held high 200 cycles of back-to-back loads -> every accept coincides with rdy=1, all responses correct, rdy low in some IDLE cycles.

Source files
------------

// File: rtl/falafel_mem_responder.sv
// Single-outstanding memory responder: load / store / compare-and-swap on an internal word array.
// Optional FALAFEL_MEM_STALL_EN adds an LFSR that pseudo-randomly withholds request readiness.
module falafel_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic [1:0]        dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Handshake: a request is taken on a rising edge where mem_req_val_i && mem_req_rdy_o;
  // a response is consumed on a rising edge where mem_rsp_val_o && mem_rsp_rdy_i.
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] mem_rd;
  logic              mem_we;
  logic              req_acc;
  logic              stall_ok;
  logic              unused_addr;

  assign req_idx     = mem_req_addr_i[OFF_W +: IDX_W];
  assign mem_rd      = mem_q[req_idx];
  assign unused_addr = ^mem_req_addr_i;

`ifdef FALAFEL_MEM_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8 + x^6 + x^5 + x^4 + 1, free-running regardless of FSM state
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= lfsr_d;
  end

  assign stall_ok = ~lfsr_q[0];
`else
  assign stall_ok = 1'b1;
`endif

  // rst_ni gates readiness so nothing looks acceptable while reset is held
  assign mem_req_rdy_o  = rst_ni & (state_q == ST_IDLE) & stall_ok;
  assign req_acc        = mem_req_val_i & mem_req_rdy_o;
  assign mem_rsp_val_o  = (state_q == ST_RESP);
  assign mem_rsp_data_o = rsp_data_q;
  assign dbg_state_o    = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_acc) begin
          if (mem_req_is_cas_i) begin
            if (mem_rd == mem_req_cas_exp_i) begin
              mem_we     = 1'b1;
              rsp_data_d = '0;
            end else begin
              rsp_data_d = DATA_W'(1);
            end
          end else if (mem_req_is_write_i) begin
            mem_we     = 1'b1;
            rsp_data_d = '0;
          end else begin
            rsp_data_d = mem_rd;
          end
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (mem_rsp_rdy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Array clears on reset so lock words start at the empty value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[req_idx] <= mem_req_data_i;
    end
  end

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Randomized bench for falafel_mem_responder with a transaction-level reference model.
module tb_falafel_mem_responder;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_val = 1'b0;
  logic          req_is_write = 1'b0;
  logic          req_is_cas = 1'b0;
  logic [DW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [DW-1:0] req_cas_exp = '0;
  logic          rsp_rdy = 1'b0;
  logic          rdy;
  logic          rsp_val;
  logic [DW-1:0] rsp_data;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  falafel_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .DATA_W(DW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .mem_req_val_i      (req_val),
    .mem_req_rdy_o      (rdy),
    .mem_req_is_write_i (req_is_write),
    .mem_req_is_cas_i   (req_is_cas),
    .mem_req_addr_i     (req_addr),
    .mem_req_data_i     (req_data),
    .mem_req_cas_exp_i  (req_cas_exp),
    .mem_rsp_val_o      (rsp_val),
    .mem_rsp_rdy_i      (rsp_rdy),
    .mem_rsp_data_o     (rsp_data),
    .dbg_state_o        (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            outstanding = 1'b0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            idle_stall = 0;
  logic [7:0]    m_lfsr;

  function automatic int idx_of(input logic [DW-1:0] a);
    return int'((a / (DW / 8)) % DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic exp_rdy_idle();
`ifdef FALAFEL_MEM_STALL_EN
    return ~m_lfsr[0];
`else
    return 1'b1;
`endif
  endfunction

  always @(negedge clk) begin
    int i;
    cyc++;
    if (!rst_n) begin
      check_eq("rst_rdy", 32'(rdy), 32'd0);
      check_eq("rst_rsp_val", 32'(rsp_val), 32'd0);
      check_eq("rst_rsp_data", rsp_data, 32'd0);
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      exp_q.delete();
      outstanding = 1'b0;
    end else if (!outstanding) begin
      check_eq("idle_rsp_val", 32'(rsp_val), 32'd0);
      check_eq("idle_rdy", 32'(rdy), 32'(exp_rdy_idle()));
      if (!rdy) idle_stall++;
      if (req_val && rdy) begin
        i = idx_of(req_addr);
        if (req_is_cas) begin
          if (m_mem[i] == req_cas_exp) begin
            m_mem[i] = req_data;
            exp_q.push_back(32'd0);
          end else begin
            exp_q.push_back(32'd1);
          end
        end else if (req_is_write) begin
          m_mem[i] = req_data;
          exp_q.push_back(32'd0);
        end else begin
          exp_q.push_back(m_mem[i]);
        end
        outstanding = 1'b1;
        acc_cyc = cyc;
      end
    end else if (cyc - acc_cyc < LATENCY) begin
      check_eq("busy_rsp_val", 32'(rsp_val), 32'd0);
      check_eq("busy_rdy", 32'(rdy), 32'd0);
    end else begin
      check_eq("resp_rsp_val", 32'(rsp_val), 32'd1);
      check_eq("resp_rdy", 32'(rdy), 32'd0);
      if (exp_q.size() == 0) check_eq("resp_queue_empty", 32'd0, 32'd1);
      else check_eq("resp_data", rsp_data, exp_q[0]);
      if (rsp_rdy) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outstanding = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit cas, input bit wr, input logic [DW-1:0] addr,
                      input logic [DW-1:0] data, input logic [DW-1:0] cexp,
                      input int hold, input bit keep, output logic [DW-1:0] got);
    bit ok;
    int rcnt;
    got = 'x;
    @(posedge clk); #1;
    req_is_cas = cas; req_is_write = wr; req_addr = addr;
    req_data = data; req_cas_exp = cexp; req_val = 1'b1; rsp_rdy = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
    end
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      req_val = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!keep) req_val = 1'b0;
    ok = 1'b0;
    rcnt = 0;
    for (int t = 0; t < 300 && !ok; t++) begin
      rsp_rdy = (rcnt >= hold);
      @(negedge clk);
      if (rsp_val) begin
        if (rsp_rdy) begin
          ok = 1'b1;
          got = rsp_data;
        end else begin
          rcnt++;
        end
      end
      if (!ok) begin
        @(posedge clk); #1;
      end
    end
    if (!ok) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    req_val = 1'b0;
    rsp_rdy = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    req_val = 1'b0;
    rsp_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] a, d, ce;
    int kind;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // store then load at the same address
    send(1'b0, 1'b1, 32'h10, 32'h1234, 32'h0, 0, 1'b0, got);
    check_eq("store_rsp", got, 32'h0);
    send(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_after_store", got, 32'h1234);

    // CAS success, CAS failure (with is_write also set), then load
    do_reset(2);
    send(1'b1, 1'b0, 32'h20, 32'h7, 32'h0, 0, 1'b0, got);
    check_eq("cas_first", got, 32'h0);
    send(1'b1, 1'b1, 32'h20, 32'h7, 32'h0, 0, 1'b0, got);
    check_eq("cas_second", got, 32'h1);
    send(1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_after_cas", got, 32'h7);
    send(1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_cleared_by_reset", got, 32'h0);

    // index wrap and ignored byte offset
    send(1'b0, 1'b1, 32'h44, 32'hAB, 32'h0, 0, 1'b0, got);
    check_eq("store_wrap_rsp", got, 32'h0);
    send(1'b0, 1'b0, 32'h04, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_wrap", got, 32'hAB);
    send(1'b0, 1'b0, 32'h06, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_offset", got, 32'hAB);

    // response held 5 cycles with the request still asserted, then back-to-back
    send(1'b0, 1'b0, 32'h44, 32'h0, 32'h0, 5, 1'b1, got);
    check_eq("held_rsp", got, 32'hAB);
    send(1'b0, 1'b1, 32'h08, 32'h99, 32'h0, 0, 1'b0, got);
    check_eq("held_next_store", got, 32'h0);

    // reset while the response is pending
    @(posedge clk); #1;
    req_is_cas = 1'b0; req_is_write = 1'b1; req_addr = 32'h30;
    req_data = 32'h55; req_val = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
    end
    if (!ok) check_eq("busy_reset_accept", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 0, 1'b0, got);
    check_eq("load_after_busy_reset", got, 32'h0);

    // randomized mix
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255));
      d  = 32'($urandom_range(0, 15));
      ce = ($urandom_range(0, 1) == 1) ? m_mem[idx_of(a)] : 32'($urandom_range(0, 15));
      send(kind == 2, (kind == 1) || ($urandom_range(0, 1) == 1 && kind == 2), a, d, ce,
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

    // back-to-back loads with valid held high
    for (int n = 0; n < 70; n++) begin
      a = 32'($urandom_range(0, 255));
      send(1'b0, 1'b0, a, 32'h0, 32'h0, 0, 1'b1, got);
    end
    bus_idle();

`ifdef FALAFEL_MEM_STALL_EN
    check_eq("stall_seen", 32'(idle_stall > 0), 32'd1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
